pc_fetch_unit: RTL and testbench

//  IF-stage PC generator and instruction-fetch sequencer for the 5-stage pipeline.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/if_skid_buf.sv | 42 ++++
 rtl/pc_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared IF-stage definitions: default fetch geometry and the fetch sequencer state encoding.
package pipeline_pkg;

    localparam int          DEF_WIDTH    = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          DEF_PC_STEP  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_KILL = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr} holding register that catches a fetch returning while IF/ID is stalled.
module if_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] instr_i,
    output logic             full_o,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] instr_o
);

    logic             full_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q <= 1'b1;
        end
    end

    // Payload is only meaningful while full_q is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign full_o  = full_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage PC register and single-outstanding instruction-fetch sequencer feeding the IF/ID register.
module pc_fetch_unit
    import pipeline_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
    parameter int               PC_STEP  = DEF_PC_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic             if_valid_o,
    output logic [WIDTH-1:0] if_pc_o,
    output logic [WIDTH-1:0] if_instr_o
);

    localparam logic [WIDTH-1:0] STEP       = WIDTH'(PC_STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP - WIDTH'(1));

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] kill_addr_q, kill_addr_d;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_pc_q, out_pc_d;
    logic [WIDTH-1:0] out_instr_q, out_instr_d;

    logic             req, ack, consumed;
    logic [WIDTH-1:0] pc_mux;
    logic             skid_load, skid_clear, skid_full;
    logic [WIDTH-1:0] skid_pc, skid_instr;

    assign req      = (state_q == ST_REQ) || (state_q == ST_KILL);
    assign ack      = imem_ack_i && req;
    assign consumed = out_vld_q && !stall_i;
    assign pc_mux   = redirect_i ? (redirect_pc_i & ALIGN_MASK) : (pc_q + STEP);

    if_skid_buf #(.WIDTH(WIDTH)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .instr_i (imem_rdata_i),
        .full_o  (skid_full),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_addr_d = kill_addr_q;
        out_vld_d   = out_vld_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;
        if (redirect_i) begin
            pc_d       = pc_mux;
            out_vld_d  = 1'b0;
            skid_clear = 1'b1;
            // An unanswered request cannot be withdrawn; park it in KILL at its original address.
            if (!ack && (state_q == ST_REQ || state_q == ST_KILL)) begin
                state_d = ST_KILL;
                if (state_q == ST_REQ) begin
                    kill_addr_d = pc_q;
                end
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            if (consumed) begin
                out_vld_d = 1'b0;
            end
            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (ack) begin
                        pc_d = pc_mux;
                        if (!out_vld_q || consumed) begin
                            out_vld_d   = 1'b1;
                            out_pc_d    = pc_q;
                            out_instr_d = imem_rdata_i;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (consumed && skid_full) begin
                        out_vld_d   = 1'b1;
                        out_pc_d    = skid_pc;
                        out_instr_d = skid_instr;
                        skid_clear  = 1'b1;
                        state_d     = ST_REQ;
                    end
                end
                ST_KILL: begin
                    if (ack) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            out_vld_q   <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_vld_q   <= out_vld_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
        end
    end

    always_ff @(posedge clk) begin
        kill_addr_q <= kill_addr_d;
    end

    assign imem_req_o  = req;
    assign imem_addr_o = (state_q == ST_KILL) ? kill_addr_q : pc_q;
    assign if_valid_o  = out_vld_q;
    assign if_pc_o     = out_pc_q;
    assign if_instr_o  = out_instr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised bench for pc_fetch_unit: an ideal in-order PC-stream model feeds a scoreboard
// queue, and a negedge monitor checks every consumed instruction plus the handshake rules.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;

    pc_fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o)
    );

    always #5 clk = ~clk;

    int          vec_cnt  = 0;
    int          err_cnt  = 0;
    int          ack_pct  = 100;
    bit          junk_ack = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] next_pc;

    // Instruction memory contents: a bijective scramble of the address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        next_pc = 32'h0000_0000;
        topup();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        topup();
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        exp_q.delete();
        next_pc = target & 32'hFFFF_FFFC;
        topup();
        step();
        redirect_i = 1'b0;
    endtask

    // Instruction memory: answers a raised request with random wait states,
    // and optionally wiggles ack while no request is pending.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            imem_ack_i = 1'b0;
        end else if (imem_req_o) begin
            imem_ack_i   = ($urandom_range(99) < ack_pct);
            imem_rdata_i = imem_ack_i ? mem_f(imem_addr_o) : $urandom;
        end else begin
            imem_ack_i   = junk_ack && ($urandom_range(99) < 20);
            imem_rdata_i = $urandom;
        end
    end

    // Monitor: sees the inputs the next rising edge will sample.
    logic        prev_pend, prev_hold, prev_redir;
    logic [31:0] prev_addr, prev_pc, prev_instr;
    int          idle_cnt;
    initial begin
        prev_pend = 1'b0; prev_hold = 1'b0; prev_redir = 1'b0;
        prev_addr = '0;   prev_pc = '0;     prev_instr = '0;
        idle_cnt = 0;
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            prev_pend  = 1'b0;
            prev_hold  = 1'b0;
            prev_redir = 1'b0;
            idle_cnt   = 0;
        end else begin
            if (prev_pend) begin
                chk("hs_req_held", 32'(imem_req_o), 32'd1);
                chk("hs_addr_stable", imem_addr_o, prev_addr);
            end
            if (prev_hold) begin
                chk("stall_vld", 32'(if_valid_o), 32'd1);
                chk("stall_pc", if_pc_o, prev_pc);
                chk("stall_instr", if_instr_o, prev_instr);
            end
            if (prev_redir) begin
                chk("redirect_flush", 32'(if_valid_o), 32'd0);
            end
            if (if_valid_o && !stall_i && !redirect_i) begin
                idle_cnt = 0;
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL sb_underflow: got pc %h, expected nothing", if_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", if_pc_o, e);
                    chk("out_instr", if_instr_o, mem_f(e));
                end
            end else begin
                idle_cnt++;
                if (idle_cnt > 400) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL progress: got %0d idle cycles, expected at most 400", idle_cnt);
                    idle_cnt = 0;
                end
            end
            prev_pend  = imem_req_o && !imem_ack_i;
            prev_addr  = imem_addr_o;
            prev_hold  = if_valid_o && stall_i && !redirect_i;
            prev_pc    = if_pc_o;
            prev_instr = if_instr_o;
            prev_redir = redirect_i;
        end
    end

    initial begin
        logic [31:0] a;
        rst_n         = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        model_reset();
        #2;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_vld", 32'(if_valid_o), 32'd0);
        chk("rst_pc", if_pc_o, 32'd0);
        chk("rst_instr", if_instr_o, 32'd0);

        // Release and stream with a zero-wait memory.
        step();
        step();
        rst_n = 1'b1;
        chk("idle_req", 32'(imem_req_o), 32'd0);
        step();
        chk("first_req", 32'(imem_req_o), 32'd1);
        chk("first_addr", imem_addr_o, 32'h0);
        step();
        chk("stream0_vld", 32'(if_valid_o), 32'd1);
        chk("stream0_pc", if_pc_o, 32'h0);
        step();
        chk("stream1_pc", if_pc_o, 32'h4);
        step();
        chk("stream2_pc", if_pc_o, 32'h8);
        chk("stream2_instr", if_instr_o, mem_f(32'h8));

        // Stall while acks keep arriving: the skid fills and requests stop.
        stall_i = 1'b1;
        repeat (4) step();
        chk("wait_req", 32'(imem_req_o), 32'd0);
        chk("wait_pc", if_pc_o, 32'h8);
        stall_i = 1'b0;
        step();
        chk("resume_pc", if_pc_o, 32'hC);
        chk("resume_req", 32'(imem_req_o), 32'd1);
        chk("resume_addr", imem_addr_o, 32'h10);

        // Redirect against an unanswered request.
        ack_pct = 0;
        step();
        step();
        a = imem_addr_o;
        chk("pend_req", 32'(imem_req_o), 32'd1);
        redirect_to(32'h0000_0103);
        chk("kill_req", 32'(imem_req_o), 32'd1);
        chk("kill_addr", imem_addr_o, a);
        chk("kill_vld", 32'(if_valid_o), 32'd0);
        step();
        ack_pct = 100;
        step();
        chk("kill_addr2", imem_addr_o, a);
        step();
        chk("post_kill_addr", imem_addr_o, 32'h100);
        chk("post_kill_vld", 32'(if_valid_o), 32'd0);
        step();
        chk("redir_first_pc", if_pc_o, 32'h100);
        chk("redir_first_vld", 32'(if_valid_o), 32'd1);

        // Redirect coinciding with an ack: that response is discarded.
        chk("coinc_ack", 32'(imem_ack_i), 32'd1);
        redirect_to(32'h0000_0200);
        chk("coinc_addr", imem_addr_o, 32'h200);
        chk("coinc_vld", 32'(if_valid_o), 32'd0);
        step();
        chk("coinc_pc", if_pc_o, 32'h200);

        // Address wrap at the top of the space.
        redirect_to(32'hFFFF_FFF8);
        chk("wrap_addr0", imem_addr_o, 32'hFFFF_FFF8);
        step();
        chk("wrap_addr1", imem_addr_o, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr2", imem_addr_o, 32'h0000_0000);
        chk("wrap_pc", if_pc_o, 32'hFFFF_FFFC);

        // Random traffic with one asynchronous reset in the middle.
        junk_ack = 1'b1;
        ack_pct  = 60;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                chk("async_rst_req", 32'(imem_req_o), 32'd0);
                chk("async_rst_vld", 32'(if_valid_o), 32'd0);
                stall_i    = 1'b0;
                redirect_i = 1'b0;
                model_reset();
                step();
                step();
                rst_n = 1'b1;
                step();
                chk("rerst_req", 32'(imem_req_o), 32'd1);
                chk("rerst_addr", imem_addr_o, 32'h0);
            end
            stall_i = ($urandom_range(99) < 30);
            if ($urandom_range(99) < 3) begin
                if ($urandom_range(3) == 0) begin
                    redirect_to(32'hFFFF_FFF0 | 32'($urandom_range(15)));
                end else begin
                    redirect_to($urandom);
                end
            end else begin
                step();
            end
        end

        // Drain.
        stall_i  = 1'b0;
        junk_ack = 1'b0;
        ack_pct  = 100;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
